// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Multiply is radix-2 shift-add over a 2*XLEN product, divide is restoring;
// both take XLEN iterations. Divide-by-zero and signed overflow finish
// without iterating.
// Optional build macro: MULDIV_FAST_MUL_EN -- when defined, all multiply ops
// use a single-cycle (2*XLEN)-bit multiplier and skip the CALC phase.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1 (IDLE or DONE). busy is high for the whole CALC phase. done is a
// one-cycle pulse while result carries the new value; result then holds
// until the next done. flush aborts an op (no done) and beats start.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // hi/lo: product halves for multiply, remainder/quotient for divide.
  logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;
  // opnd: multiplicand magnitude, or divisor magnitude.
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [2:0]         f3_q, f3_d;
  logic               nega_q, nega_d, negb_q, negb_d;
  logic [XLEN-1:0]    result_q, result_d;

  // Request decode: sign handling and early-out detection on the raw inputs.
  logic            a_signed, b_signed, neg_a_in, neg_b_in, is_div_in;
  logic            div0_in, ovf_in, fast_hit;
  logic [XLEN-1:0] mag_a_in, mag_b_in, fast_val;

  assign a_signed  = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                     (funct3 == F_DIV)  || (funct3 == F_REM);
  assign b_signed  = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign neg_a_in  = a_signed & op_a[XLEN-1];
  assign neg_b_in  = b_signed & op_b[XLEN-1];
  assign mag_a_in  = neg_a_in ? -op_a : op_a;
  assign mag_b_in  = neg_b_in ? -op_b : op_b;
  assign is_div_in = funct3[2];
  assign div0_in   = is_div_in && (op_b == '0);
  assign ovf_in    = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                     (op_a == MIN_NEG) && (op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
  // One extra sign bit lets one signed multiplier serve all four mul flavours.
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;
  assign fast_a    = {neg_a_in, op_a};
  assign fast_b    = {neg_b_in, op_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_hit  = !is_div_in;
  assign fast_val  = (funct3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_hit  = 1'b0;
  assign fast_val  = '0;
`endif

  // One iteration of each algorithm on the registered datapath.
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] div_sub, step_hi, step_lo;
  logic            div_ge;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh  = {hi_q, lo_q[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  // When div_ge the difference is below the divisor, so XLEN bits suffice.
  assign div_sub = div_sh[XLEN-1:0] - opnd_q;
  assign step_hi = f3_q[2] ? (div_ge ? div_sub : div_sh[XLEN-1:0]) : mul_sum[XLEN:1];
  assign step_lo = f3_q[2] ? {lo_q[XLEN-2:0], div_ge} : {mul_sum[0], lo_q[XLEN-1:1]};

  // Sign fix-up applied to the values produced by the final iteration.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_val;

  assign prod_fix = (nega_q ^ negb_q) ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign quot_fix = (nega_q ^ negb_q) ? -step_lo : step_lo;
  assign rem_fix  = nega_q ? -step_hi : step_hi;

  // Select the architectural result for the registered op.
  always_comb begin
    final_val = '0;
    case (f3_q)
      F_MUL:        final_val = prod_fix[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:       final_val = prod_fix[2*XLEN-1:XLEN];
      3'b100,
      3'b101:       final_val = quot_fix;
      default:      final_val = rem_fix;
    endcase
  end

  // Next-state, datapath capture/iteration and result update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    nega_d   = nega_q;
    negb_d   = negb_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (start) begin
          f3_d   = funct3;
          nega_d = neg_a_in;
          negb_d = neg_b_in;
          cnt_d  = '0;
          hi_d   = '0;
          lo_d   = is_div_in ? mag_a_in : mag_b_in;
          opnd_d = is_div_in ? mag_b_in : mag_a_in;
          if (div0_in) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? op_a : '1;
          end else if (ovf_in) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? '0 : op_a;
          end else if (fast_hit) begin
            state_d  = S_DONE;
            result_d = fast_val;
          end else begin
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          // This edge performs the XLEN-th iteration: count reaches XLEN.
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d  = S_DONE;
            result_d = final_val;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      nega_q   <= 1'b0;
      negb_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      nega_q   <= nega_d;
      negb_q   <= negb_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q != S_CALC);
  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
